regfile_wb_ctrl: RTL and testbench

Writeback controller that drives the register file write port (wb_en, rd_index, wb_data) from two producers: the single-cycle ALU pipe and a long-latency unit (load/MUL/DIV). It buffers long-latency results in a small FIFO, arbitrates with a starvation guard, and keeps a pending-destination scoreboard that decode uses to stall reads of registers not yet written. It sits between the execute units and the register file, on the write side of the port that decode reads.

---
 rtl/regfile_wb_ctrl_pkg.sv | 13 +
 rtl/regfile_wb_ctrl_fifo.sv | 70 +++++++
 rtl/regfile_wb_ctrl.sv | 131 +++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared definitions for the register-file writeback controller.
package regfile_wb_ctrl_pkg;

   localparam int WB_XLEN   = 32;
   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 32;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [WB_XLEN-1:0]   data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_wb_ctrl_fifo.sv
// Small synchronous FIFO that buffers long-latency results.
// It has full and empty flags and supports a push and a pop in the same cycle.
module wb_fifo
   import regfile_wb_ctrl_pkg::*;
#(
   parameter int WIDTH = REG_IDX_W + WB_XLEN,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign pop_data = mem_q[rd_ptr_q];
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;

   // Pointer, occupancy and storage updates; a push and a pop together leave occupancy unchanged
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers; reset empties the FIFO and discards buffered data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller for the register file write port. It merges ALU results
// with buffered long-unit results, uses a starvation guard so the FIFO head is
// not held off forever, and tracks pending long-unit destinations for decode.
module regfile_wb_ctrl
   import regfile_wb_ctrl_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 iss_valid,
   input  logic                 iss_long,
   input  logic [REG_IDX_W-1:0] iss_rd,
   input  logic [REG_IDX_W-1:0] rs1_index,
   input  logic [REG_IDX_W-1:0] rs2_index,
   output logic                 rs1_busy,
   output logic                 rs2_busy,
   input  logic                 alu_wb_valid,
   output logic                 alu_ready,
   input  logic [REG_IDX_W-1:0] alu_rd,
   input  logic [XLEN-1:0]      alu_data,
   input  logic                 lu_valid,
   output logic                 lu_ready,
   input  logic [REG_IDX_W-1:0] lu_rd,
   input  logic [XLEN-1:0]      lu_data,
   output logic                 wb_en,
   output logic [REG_IDX_W-1:0] rd_index,
   output logic [XLEN-1:0]      wb_data
);

   localparam int ENTRY_W = REG_IDX_W + XLEN;
   localparam int SW      = $clog2(STARVE_MAX + 1);

   logic [ENTRY_W-1:0]   fifo_head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 alu_win;
   logic [REG_IDX_W-1:0] head_rd;
   logic [XLEN-1:0]      head_data;

   logic [NUM_REGS-1:0]  pend_q, pend_d;
   logic [SW-1:0]        starve_q, starve_d;
   logic                 wb_en_q, wb_en_d;
   logic [REG_IDX_W-1:0] rd_index_q, rd_index_d;
   logic [XLEN-1:0]      wb_data_q, wb_data_d;

   assign head_rd   = fifo_head[XLEN +: REG_IDX_W];
   assign head_data = fifo_head[XLEN-1:0];

   assign lu_ready  = !fifo_full;
   assign fifo_push = lu_valid && lu_ready;
   assign alu_ready = !(!fifo_empty && (starve_q == SW'(STARVE_MAX)));
   assign alu_win   = alu_wb_valid && alu_ready;
   assign fifo_pop  = !alu_win && !fifo_empty;

   assign rs1_busy  = pend_q[rs1_index];
   assign rs2_busy  = pend_q[rs2_index];

   assign wb_en     = wb_en_q;
   assign rd_index  = rd_index_q;
   assign wb_data   = wb_data_q;

   wb_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data ({lu_rd, lu_data}),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Arbitration, starvation counting, scoreboard update and output register loading
   always_comb begin
      wb_en_d    = 1'b0;
      rd_index_d = rd_index_q;
      wb_data_d  = wb_data_q;
      starve_d   = starve_q;
      pend_d     = pend_q;

      if (alu_win) begin
         wb_en_d    = (alu_rd != '0);
         rd_index_d = alu_rd;
         wb_data_d  = alu_data;
      end else if (fifo_pop) begin
         wb_en_d    = (head_rd != '0);
         rd_index_d = head_rd;
         wb_data_d  = head_data;
      end

      if (fifo_empty || fifo_pop) begin
         starve_d = '0;
      end else if (alu_win && (starve_q != SW'(STARVE_MAX))) begin
         starve_d = starve_q + SW'(1);
      end

      if (fifo_pop) begin
         pend_d[head_rd] = 1'b0;
      end
      if (iss_valid && iss_long && (iss_rd != '0)) begin
         pend_d[iss_rd] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   // State registers; reset drops the scoreboard, the starvation count and the write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q     <= '0;
         starve_q   <= '0;
         wb_en_q    <= 1'b0;
         rd_index_q <= '0;
         wb_data_q  <= '0;
      end else begin
         pend_q     <= pend_d;
         starve_q   <= starve_d;
         wb_en_q    <= wb_en_d;
         rd_index_q <= rd_index_d;
         wb_data_q  <= wb_data_d;
      end
   end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed testbench for regfile_wb_ctrl with hand-computed expectations.
module tb_regfile_wb_ctrl;

   logic        clk;
   logic        rst_n;
   logic        iss_valid;
   logic        iss_long;
   logic [4:0]  iss_rd;
   logic [4:0]  rs1_index;
   logic [4:0]  rs2_index;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        alu_wb_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_rd;
   logic [31:0] lu_data;
   logic        wb_en;
   logic [4:0]  rd_index;
   logic [31:0] wb_data;

   int checks = 0;
   int errors = 0;

   regfile_wb_ctrl #(
      .XLEN       (32),
      .FIFO_DEPTH (2),
      .STARVE_MAX (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .iss_valid    (iss_valid),
      .iss_long     (iss_long),
      .iss_rd       (iss_rd),
      .rs1_index    (rs1_index),
      .rs2_index    (rs2_index),
      .rs1_busy     (rs1_busy),
      .rs2_busy     (rs2_busy),
      .alu_wb_valid (alu_wb_valid),
      .alu_ready    (alu_ready),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .lu_valid     (lu_valid),
      .lu_ready     (lu_ready),
      .lu_rd        (lu_rd),
      .lu_data      (lu_data),
      .wb_en        (wb_en),
      .rd_index     (rd_index),
      .wb_data      (wb_data)
   );

   // Free-running clock, 10 time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle's worth of producer inputs
   task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                                input logic iv, input logic il, input logic [4:0] ird);
      alu_wb_valid = av;
      alu_rd       = ard;
      alu_data     = adata;
      lu_valid     = lv;
      lu_rd        = lrd;
      lu_data      = ldata;
      iss_valid    = iv;
      iss_long     = il;
      iss_rd       = ird;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      rs1_index = 5'd0;
      rs2_index = 5'd0;
      idle();

      // Reset state
      tick();
      tick();
      checkOutput("rst_wb_en", 64'(wb_en), 64'd0);
      checkOutput("rst_rd_index", 64'(rd_index), 64'd0);
      checkOutput("rst_wb_data", 64'(wb_data), 64'd0);
      checkOutput("rst_lu_ready", 64'(lu_ready), 64'd1);
      checkOutput("rst_alu_ready", 64'(alu_ready), 64'd1);
      rst_n = 1'b1;
      tick();

      // ALU only path
      $display("[TB] ALU path");
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
      tick();
      checkOutput("alu_wb_en", 64'(wb_en), 64'd1);
      checkOutput("alu_rd_index", 64'(rd_index), 64'd5);
      checkOutput("alu_wb_data", 64'(wb_data), 64'hDEADBEEF);
      applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
      tick();
      checkOutput("alu_rd0_wb_en", 64'(wb_en), 64'd0);
      idle();
      tick();
      checkOutput("alu_idle_wb_en", 64'(wb_en), 64'd0);

      // Long path with scoreboard
      $display("[TB] long path and scoreboard");
      rs1_index = 5'd7;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd7);
      checkOutput("sb_busy_before_issue", 64'(rs1_busy), 64'd0);
      tick();
      checkOutput("sb_busy_after_issue", 64'(rs1_busy), 64'd1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 1'b0, 5'd0);
      checkOutput("lu_ready_empty", 64'(lu_ready), 64'd1);
      tick();
      checkOutput("sb_busy_after_hs", 64'(rs1_busy), 64'd1);
      checkOutput("lu_wb_en_n1", 64'(wb_en), 64'd0);
      idle();
      tick();
      checkOutput("lu_wb_en_n2", 64'(wb_en), 64'd1);
      checkOutput("lu_rd_index", 64'(rd_index), 64'd7);
      checkOutput("lu_wb_data", 64'(wb_data), 64'h1234);
      checkOutput("sb_busy_cleared", 64'(rs1_busy), 64'd0);
      tick();
      checkOutput("hold_wb_en", 64'(wb_en), 64'd0);
      checkOutput("hold_rd_index", 64'(rd_index), 64'd7);
      checkOutput("hold_wb_data", 64'(wb_data), 64'h1234);

      // Starvation guard
      $display("[TB] starvation guard");
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hAAA, 1'b0, 1'b0, 5'd0);
      tick();
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 5'd10, 32'(i), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
         checkOutput("starve_alu_ready_pre", 64'(alu_ready), 64'd1);
         tick();
         checkOutput("starve_alu_rd", 64'(rd_index), 64'd10);
         checkOutput("starve_alu_data", 64'(wb_data), 64'(i));
      end
      checkOutput("starve_held_off", 64'(alu_ready), 64'd0);
      tick();
      checkOutput("starve_head_wb_en", 64'(wb_en), 64'd1);
      checkOutput("starve_head_rd", 64'(rd_index), 64'd3);
      checkOutput("starve_head_data", 64'(wb_data), 64'hAAA);
      checkOutput("starve_ready_back", 64'(alu_ready), 64'd1);
      tick();
      checkOutput("starve_alu_resume", 64'(rd_index), 64'd10);
      idle();
      tick();

      // Full FIFO, order preservation and push+pop in one cycle
      $display("[TB] full FIFO");
      applyStimulus(1'b1, 5'd10, 32'hF0, 1'b1, 5'd11, 32'hA1, 1'b0, 1'b0, 5'd0);
      tick();
      applyStimulus(1'b1, 5'd10, 32'hF1, 1'b1, 5'd12, 32'hB2, 1'b0, 1'b0, 5'd0);
      checkOutput("full_lu_ready_one", 64'(lu_ready), 64'd1);
      tick();
      checkOutput("full_lu_ready_zero", 64'(lu_ready), 64'd0);
      applyStimulus(1'b1, 5'd10, 32'hF2, 1'b1, 5'd13, 32'hC3, 1'b0, 1'b0, 5'd0);
      tick();
      checkOutput("full_still_full", 64'(lu_ready), 64'd0);
      tick();
      tick();
      checkOutput("full_alu_held", 64'(alu_ready), 64'd0);
      tick();
      checkOutput("full_pop_a_rd", 64'(rd_index), 64'd11);
      checkOutput("full_pop_a_data", 64'(wb_data), 64'hA1);
      checkOutput("full_lu_ready_after_pop", 64'(lu_ready), 64'd1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hC3, 1'b0, 1'b0, 5'd0);
      tick();
      checkOutput("pushpop_b_rd", 64'(rd_index), 64'd12);
      checkOutput("pushpop_b_data", 64'(wb_data), 64'hB2);
      checkOutput("pushpop_lu_ready", 64'(lu_ready), 64'd1);
      idle();
      tick();
      checkOutput("pushpop_c_rd", 64'(rd_index), 64'd13);
      checkOutput("pushpop_c_data", 64'(wb_data), 64'hC3);
      tick();
      checkOutput("pushpop_drained", 64'(wb_en), 64'd0);

      // Scoreboard set/clear collision
      $display("[TB] scoreboard collision");
      rs2_index = 5'd9;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd9);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 5'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd9);
      tick();
      checkOutput("coll_wb_rd", 64'(rd_index), 64'd9);
      checkOutput("coll_wb_data", 64'(wb_data), 64'h99);
      checkOutput("coll_busy_set_wins", 64'(rs2_busy), 64'd1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9A, 1'b0, 1'b0, 5'd0);
      tick();
      checkOutput("coll_busy_pending", 64'(rs2_busy), 64'd1);
      idle();
      tick();
      checkOutput("coll_busy_cleared", 64'(rs2_busy), 64'd0);
      checkOutput("coll_second_data", 64'(wb_data), 64'h9A);

      // Async reset mid-drain
      $display("[TB] async reset");
      rs1_index = 5'd20;
      rs2_index = 5'd21;
      applyStimulus(1'b1, 5'd10, 32'hE0, 1'b1, 5'd20, 32'hD1, 1'b1, 1'b1, 5'd20);
      tick();
      applyStimulus(1'b1, 5'd10, 32'hE1, 1'b1, 5'd21, 32'hD2, 1'b1, 1'b1, 5'd21);
      tick();
      checkOutput("pre_rst_full", 64'(lu_ready), 64'd0);
      checkOutput("pre_rst_busy1", 64'(rs1_busy), 64'd1);
      checkOutput("pre_rst_busy2", 64'(rs2_busy), 64'd1);
      rst_n = 1'b0;
      idle();
      #1;
      checkOutput("arst_wb_en", 64'(wb_en), 64'd0);
      checkOutput("arst_rd_index", 64'(rd_index), 64'd0);
      checkOutput("arst_wb_data", 64'(wb_data), 64'd0);
      checkOutput("arst_lu_ready", 64'(lu_ready), 64'd1);
      checkOutput("arst_alu_ready", 64'(alu_ready), 64'd1);
      checkOutput("arst_busy1", 64'(rs1_busy), 64'd0);
      checkOutput("arst_busy2", 64'(rs2_busy), 64'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("post_rst_no_write", 64'(wb_en), 64'd0);
      end
      checkOutput("post_rst_busy1", 64'(rs1_busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
